// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the HI/LO registers.
// Radix-2^MUL_ITER_BITS shift-add multiplier and restoring 1 bit/cycle divider share one 2*WIDTH shift register.
module mips_muldiv_unit #(
    parameter int WIDTH         = 32,
    parameter int MUL_ITER_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int K     = MUL_ITER_BITS;
    localparam int MUL_N = WIDTH / K;
    localparam int CW    = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t              state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]  prod_reg;
    logic [WIDTH-1:0]    opnd_reg;
    logic [WIDTH-1:0]    dividend_reg;
    logic                is_div_reg;
    logic                neg_lo_reg;
    logic                neg_hi_reg;
    logic                dbz_reg;
    logic [WIDTH-1:0]    hi_reg;
    logic [WIDTH-1:0]    lo_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                dbz_pulse_reg;

    // Operand decode for the launch cycle
    logic                is_signed;
    logic                rs_neg;
    logic                rt_neg;
    logic [WIDTH-1:0]    rs_mag;
    logic [WIDTH-1:0]    rt_mag;

    always_comb begin
        is_signed = ~op[0];
        rs_neg    = is_signed & rs_val[WIDTH-1];
        rt_neg    = is_signed & rt_val[WIDTH-1];
        rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
    end

    // Multiplier step: add opnd * (low K bits of multiplier) into the upper half, then shift right by K
    logic [WIDTH+K-1:0]  pp [K];
    logic [WIDTH+K-1:0]  mul_sum;
    logic [2*WIDTH-1:0]  mul_next;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_pp
            assign pp[gi] = prod_reg[gi] ? ({{K{1'b0}}, opnd_reg} << gi) : '0;
        end
    endgenerate

    always_comb begin
        mul_sum = {{K{1'b0}}, prod_reg[2*WIDTH-1:WIDTH]};
        for (int i = 0; i < K; i++) begin
            mul_sum = mul_sum + pp[i];
        end
        mul_next = {mul_sum, prod_reg[WIDTH-1:K]};
    end

    // Divider step: upper half is the partial remainder, lower half shifts dividend out / quotient in
    logic [WIDTH:0]      div_shift;
    logic [WIDTH:0]      div_diff;
    logic                div_ge;
    logic [2*WIDTH-1:0]  div_next;

    always_comb begin
        div_shift = {prod_reg[2*WIDTH-1:WIDTH], prod_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        div_ge    = (div_shift >= {1'b0, opnd_reg});
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     prod_reg[WIDTH-2:0], div_ge};
    end

    // Sign fix-up applied on the FIX->DONE edge
    logic [2*WIDTH-1:0]  prod_neg;
    logic [WIDTH-1:0]    fix_hi;
    logic [WIDTH-1:0]    fix_lo;
    logic [CW-1:0]       last_cnt;

    always_comb begin
        prod_neg = ~prod_reg + 1'b1;
        last_cnt = is_div_reg ? CW'(WIDTH - 1) : CW'(MUL_N - 1);
        if (!is_div_reg) begin
            {fix_hi, fix_lo} = neg_lo_reg ? prod_neg : prod_reg;
        end else if (dbz_reg) begin
            fix_hi = dividend_reg;
            fix_lo = '1;
        end else begin
            fix_lo = neg_lo_reg ? (~prod_reg[WIDTH-1:0] + 1'b1) : prod_reg[WIDTH-1:0];
            fix_hi = neg_hi_reg ? (~prod_reg[2*WIDTH-1:WIDTH] + 1'b1) : prod_reg[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            prod_reg      <= '0;
            opnd_reg      <= '0;
            dividend_reg  <= '0;
            is_div_reg    <= 1'b0;
            neg_lo_reg    <= 1'b0;
            neg_hi_reg    <= 1'b0;
            dbz_reg       <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_pulse_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            dbz_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= RUN;
                        busy_reg     <= 1'b1;
                        cnt_reg      <= '0;
                        is_div_reg   <= op[1];
                        dividend_reg <= rs_val;
                        dbz_reg      <= op[1] & (rt_val == '0);
                        neg_lo_reg   <= rs_neg ^ rt_neg;
                        neg_hi_reg   <= op[1] ? rs_neg : (rs_neg ^ rt_neg);
                        if (op[1]) begin
                            prod_reg <= {{WIDTH{1'b0}}, rs_mag};
                            opnd_reg <= rt_mag;
                        end else begin
                            prod_reg <= {{WIDTH{1'b0}}, rt_mag};
                            opnd_reg <= rs_mag;
                        end
                    end else begin
                        if (mthi) hi_reg <= rs_val;
                        if (mtlo) lo_reg <= rs_val;
                    end
                end
                RUN: begin
                    prod_reg <= is_div_reg ? div_next : mul_next;
                    cnt_reg  <= cnt_reg + 1'b1;
                    if (cnt_reg == last_cnt) state_reg <= FIX;
                end
                FIX: begin
                    hi_reg        <= fix_hi;
                    lo_reg        <= fix_lo;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    dbz_pulse_reg <= dbz_reg;
                    state_reg     <= DONE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_pulse_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: scoreboard of expected HI/LO results from a behavioural model,
// with a second instance at MUL_ITER_BITS=4 checked for latency and results on the same stimulus.
module tb_mips_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    logic        busy4, done4, div_by_zero4;
    logic [31:0] hi4, lo4;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32), .MUL_ITER_BITS(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    mips_muldiv_unit #(.WIDTH(32), .MUL_ITER_BITS(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .mthi(mthi), .mtlo(mtlo), .busy(busy4), .done(done4), .div_by_zero(div_by_zero4),
        .hi(hi4), .lo(lo4)
    );

    typedef struct {
        string       tag;
        logic [63:0] hilo;
        logic        dbz;
        int          lat;
        int          lat4;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("check %-28s observed %h expected %h", tag, obs, expv);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference result {div_by_zero, hi, lo} from native arithmetic
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        model = '0;
        case (o)
            2'd0: begin p = sa * sb; model = {1'b0, p}; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; model = {1'b0, p}; end
            default: begin
                if (b == 32'd0) begin
                    model = {1'b1, a, 32'hFFFFFFFF};
                end else begin
                    if (o == 2'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'b0, a}) / longint'({32'b0, b});
                        r = longint'({32'b0, a}) % longint'({32'b0, b});
                    end
                    model = {1'b0, r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    // Pushes an expectation at launch; done appears N+1 edges after the start edge (N+2 busy/done cycles)
    task automatic launch(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_mt);
        exp_t        e;
        logic [64:0] m;
        m      = model(o, a, b);
        e.tag  = tag;
        e.hilo = m[63:0];
        e.dbz  = m[64];
        e.lat  = 33;
        e.lat4 = o[1] ? 33 : 9;
        sb_q.push_back(e);
        $display("launch %s op=%0d rs=%h rt=%h", tag, o, a, b);
        start  = 1'b1; op = o; rs_val = a; rt_val = b;
        mthi   = with_mt; mtlo = with_mt;
        tick;
        start  = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
    endtask

    // Waits for done on both instances (bounded), pops the scoreboard and compares
    task automatic finish_op(input int cyc0);
        exp_t        e;
        int          cyc, cyc4;
        logic [63:0] hilo4;
        logic        dbz4;
        cyc   = cyc0;
        cyc4  = -1;
        hilo4 = '0;
        dbz4  = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
            if (done4 === 1'b1 && cyc4 < 0) begin
                cyc4  = cyc;
                hilo4 = {hi4, lo4};
                dbz4  = div_by_zero4;
            end
        end
        e = sb_q.pop_front();
        check({e.tag, " latency"}, 64'(cyc), 64'(e.lat));
        check({e.tag, " hilo"}, {hi, lo}, e.hilo);
        check({e.tag, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
        check({e.tag, " busy@done"}, 64'(busy), 64'd0);
        check({e.tag, " r4 latency"}, 64'(cyc4), 64'(e.lat4));
        check({e.tag, " r4 hilo"}, hilo4, e.hilo);
        check({e.tag, " r4 dbz"}, 64'(dbz4), 64'(e.dbz));
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_mt);
        logic [63:0] prev;
        prev = {hi, lo};
        launch(tag, o, a, b, with_mt);
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " hold"}, {hi, lo}, prev);
        finish_op(0);
        tick;
        check({tag, " done pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        int          pulses;
        reset = 1'b1; start = 1'b0; op = 2'd0; rs_val = '0; rt_val = '0; mthi = 1'b0; mtlo = 1'b0;
        tick; tick;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;
        tick;

        mthi = 1'b1; rs_val = 32'h1234; tick; mthi = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234);
        check("mthi lo", 64'(lo), 64'h0);
        mtlo = 1'b1; rs_val = 32'h5678; tick; mtlo = 1'b0;
        check("mtlo lo", 64'(lo), 64'h5678);
        check("mtlo hi", 64'(hi), 64'h1234);
        mthi = 1'b1; mtlo = 1'b1; rs_val = 32'hA5A5_0001; tick; mthi = 1'b0; mtlo = 1'b0;
        check("mthi+mtlo", {hi, lo}, 64'hA5A5_0001_A5A5_0001);

        run_op("multu ffff*ffff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op("mult -3*7", 2'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op("div -7/2", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op("divu 100/7 +mt", 2'd3, 32'd100, 32'd7, 1'b1);
        run_op("divu 5/0", 2'd3, 32'd5, 32'd0, 1'b0);
        run_op("div 8000/-1", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("div 7/-2", 2'd2, 32'd7, 32'hFFFFFFFE, 1'b0);
        run_op("div -9/0", 2'd2, 32'hFFFFFFF7, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("rand op%0d", i), 2'(i), $urandom, $urandom, 1'b0);
        end

        // MTHI and a second start while busy are ignored; a start in DONE is not queued
        prev = {hi, lo};
        launch("divu 1000/9 busy", 2'd3, 32'd1000, 32'd9, 1'b0);
        mthi = 1'b1; rs_val = 32'hDEAD; tick; mthi = 1'b0;
        check("mthi in busy", {hi, lo}, prev);
        start = 1'b1; op = 2'd1; rs_val = 32'd3; rt_val = 32'd5; tick; start = 1'b0;
        check("start in busy", 64'(busy), 64'd1);
        finish_op(2);
        start = 1'b1; op = 2'd1; rs_val = 32'd7; rt_val = 32'd7; tick; start = 1'b0;
        check("start in done busy", 64'(busy), 64'd0);
        check("start in done done", 64'(done), 64'd0);
        run_op("mult after done", 2'd0, 32'd6, 32'hFFFFFFF9, 1'b0);

        // Reset at cycle 10 of a DIV aborts it
        start = 1'b1; op = 2'd2; rs_val = 32'hFFFFFF9C; rt_val = 32'd3; tick; start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        reset = 1'b1; tick; reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, 64'd0);
        check("abort done", 64'(done), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done === 1'b1 || done4 === 1'b1) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);
        check("abort hilo later", {hi, lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
